csa_pipe_adder: RTL and testbench
=================================

// Module: csa_pipe_adder
// PURPOSE
//  Parametrised, pipelined conditional-sum adder/subtractor. Successor to the fixed 7-bit
//  combinational conditional-sum cell: generalised WIDTH, optional register per merge level.
//  Adds valid/ready handshake with backpressure, subtract mode, signed overflow and saturation.
//  Sits between operand-fetch and result-writeback stages of the datapath.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=1)
//  PIPE    1   0: one output register only; 1: register after every conditional-sum merge level
//  SAT     0   1: on signed overflow, clamp sum to signed max/min
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands x,y,cin,sub valid this cycle
//  in_ready   out  1      block can accept operands this cycle
//  x          in   WIDTH  operand A
//  y          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      1: compute x - y
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out (sub mode: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits, out_valid, sum, cout, ovf -> 0. in_ready
//    follows the comb rule below, so it is 1 during and after reset.
//  - LEVELS = $clog2(WIDTH); WIDTH=1 -> LEVELS=0. Latency L = PIPE ? LEVELS+1 : 1 cycles from
//    accepted input to out_valid, absent stalls.
//  - Arithmetic: yy = sub ? ~y : y; c0 = sub ? 1 : cin; {cout,sum_raw} = x + yy + c0, exact mod 2^WIDTH.
//    ovf = (x[MSB]==yy[MSB]) && (sum_raw[MSB]!=x[MSB]).
//    SAT=1 and ovf: sum = x[MSB] ? 100..0 : 011..1; cout, ovf unchanged. SAT=0: sum = sum_raw.
//  - Structure: level 0 per bit {s0,s1,c0,c1}. Level k merges 2^k-bit blocks; the lower block's
//    carry selects the upper block's pair. The cin/sub-resolved carry ripples through the
//    select chain. Non-power-of-2 WIDTH: top block is partial; no extra cycles.
//  - Handshake (global stall): stall = out_valid && !out_ready; in_ready = !stall (comb).
//    Input accepted when in_valid && in_ready.
//  - No stall: every stage advances one position per clock. Idle input enters a bubble
//    (valid=0), so bubbles are not collapsed.
//  - Stall: all stage data and valid registers hold; sum/cout/ovf stable while out_valid=1.
//  - Result consumed when out_valid && out_ready. Accept and consume in the same cycle give
//    full throughput: 1 op/cycle.
//  - in_valid while in_ready=0: ignored; operands not captured and the source must hold them.
//  - Data in stages with valid=0 is don't-care but must not produce X on outputs.
//  - Reset mid-operation: all in-flight ops discarded; first accept after reset emerges L cycles later.
// TESTING (WIDTH=16, SAT=0 unless noted; PIPE=1 -> L=5)
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, in_ready=1; release, accept
//    x=1,y=1,cin=0 -> out_valid at cycle 5, sum=0x0002, cout=0.
//  2 Carry chain: x=0xFFFF, y=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; x=0x7FFF, y=1, cin=0
//    -> sum=0x8000, ovf=1. With SAT=1 the second case gives sum=0x7FFF.
//  3 Subtract: x=5, y=7, sub=1 -> sum=0xFFFE, cout=0; x=0x8000, y=1, sub=1 -> sum=0x7FFF, ovf=1.
//  4 Backpressure: stream 8 ops back-to-back, out_ready=0 for cycles 6-9 -> in_ready=0 those cycles,
//    outputs held stable, no op lost or duplicated, results in order.
//  5 Reset mid-flight: 3 ops in pipe, pulse rst_n low for 1 cycle -> none emerge; a new op appears
//    after exactly 5 cycles.
//  6 Sweep: PIPE in {0,1}, WIDTH in {1,7,16,33}, 10k random ops vs reference model -> zero
//    mismatches; latency equals L.

Source files
------------

// File: rtl/csa_pipe_adder_if.sv
// Operand/result bus of the conditional-sum adder.
//   in_valid/in_ready : operand handshake (x, y, cin, sub qualified by in_valid)
//   out_valid/out_ready: result handshake (sum, cout, ovf qualified by out_valid)
// Modports:
//   master : the datapath side that supplies operands and consumes results
//   slave  : the adder itself
interface csa_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined conditional-sum adder/subtractor with signed overflow and optional
// saturation.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : csa_pipe_adder_if.slave (operands x/y/cin/sub in, sum/cout/ovf out)
// Parameters:
//   WIDTH : operand/result width (>= 1)
//   PIPE  : 0 = output register only, 1 = register after every merge level
//   SAT   : 1 = clamp sum to signed max/min on overflow
//
// Handshake: an operand set transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The whole
// pipe stalls (every stage holds) while out_valid && !out_ready, and in_ready is
// the combinational inverse of that stall. While out_valid is high the result
// fields do not change until the result is taken.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter bit PIPE  = 1'b1,
  parameter bit SAT   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  csa_pipe_adder_if.slave  bus
);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

  // Conditional-sum data at one level. s0/s1 are the per-bit sums assuming a
  // carry-in of 0/1 into the bit's current block; c0/c1 hold the matching block
  // carry-outs indexed by block number (one spare bit so the sibling lookup of
  // an odd-width top block never indexes past the end). Block 0 always carries
  // the resolved cin/sub carry, so its s0==s1 and c0==c1.
  typedef struct packed {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH:0]   c0;
    logic [WIDTH:0]   c1;
    logic             xm;
    logic             ym;
  } lvl_t;

  function automatic lvl_t level0(input logic [WIDTH-1:0] xa, ya,
                                  input logic ci, sb);
    lvl_t             r;
    logic [WIDTH-1:0] yy, p, g;
    logic             cr;
    yy = sb ? ~ya : ya;
    cr = sb | ci;
    p  = xa ^ yy;
    g  = xa & yy;
    r.s0 = p;
    r.s1 = ~p;
    r.c0 = '0;
    r.c1 = '0;
    r.c0[WIDTH-1:0] = g;
    r.c1[WIDTH-1:0] = xa | yy;
    // Bit 0 sees the real carry-in, so both of its hypotheses collapse.
    r.s0[0] = p[0] ^ cr;
    r.s1[0] = p[0] ^ cr;
    r.c0[0] = g[0] | (p[0] & cr);
    r.c1[0] = g[0] | (p[0] & cr);
    r.xm = xa[WIDTH-1];
    r.ym = yy[WIDTH-1];
    return r;
  endfunction

  // Merge pairs of 2^(k-1)-bit blocks into 2^k-bit blocks: the lower block's
  // carry hypotheses choose between the upper block's sum/carry pairs.
  function automatic lvl_t merge(input int k, input lvl_t a);
    lvl_t r;
    int   h;
    int   j;
    r = a;
    h = 1 << (k - 1);
    for (int i = 0; i < WIDTH; i++) begin
      j = i / h;
      if (j % 2 == 1) begin
        r.s0[i] = a.c0[j-1] ? a.s1[i] : a.s0[i];
        r.s1[i] = a.c1[j-1] ? a.s1[i] : a.s0[i];
      end
    end
    r.c0 = '0;
    r.c1 = '0;
    for (int b = 0; b < (WIDTH + 1) / 2; b++) begin
      if ((2 * b + 1) * h < WIDTH) begin
        r.c0[b] = a.c0[2*b] ? a.c1[2*b+1] : a.c0[2*b+1];
        r.c1[b] = a.c1[2*b] ? a.c1[2*b+1] : a.c0[2*b+1];
      end else if (2 * b * h < WIDTH) begin
        // Partial top block with no upper sibling: passes through unchanged.
        r.c0[b] = a.c0[2*b];
        r.c1[b] = a.c1[2*b];
      end
    end
    return r;
  endfunction

  logic             stall;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  lvl_t lvl [0:LEVELS];
  logic vld [0:LEVELS];

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  assign lvl[0] = level0(bus.x, bus.y, bus.cin, bus.sub);
  assign vld[0] = bus.in_valid && !stall;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    if (PIPE) begin : g_reg
      lvl_t d_q;
      logic v_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else if (!stall) begin
          // Bubbles advance too, so idle cycles keep their slot.
          d_q <= lvl[k-1];
          v_q <= vld[k-1];
        end
      end
      assign lvl[k] = merge(k, d_q);
      assign vld[k] = v_q;
    end else begin : g_comb
      assign lvl[k] = merge(k, lvl[k-1]);
      assign vld[k] = vld[k-1];
    end
  end

  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_n;
  logic [WIDTH-1:0] msb_only;
  logic             ovf_n;

  always_comb begin
    msb_only          = '0;
    msb_only[WIDTH-1] = 1'b1;
    sum_raw           = lvl[LEVELS].s0;
    ovf_n = (lvl[LEVELS].xm == lvl[LEVELS].ym) && (sum_raw[WIDTH-1] != lvl[LEVELS].xm);
    sum_n = sum_raw;
    if (SAT && ovf_n) begin
      // Overflow direction follows the sign of x: negative clamps to min.
      sum_n = lvl[LEVELS].xm ? msb_only : ~msb_only;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= vld[LEVELS];
      // Result fields load only with a real op, so bubble data never reaches them.
      if (vld[LEVELS]) begin
        sum_q  <= sum_n;
        cout_q <= lvl[LEVELS].c0[0];
        ovf_q  <= ovf_n;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: main instance WIDTH=16 PIPE=1 SAT=0 (latency 5),
// plus WIDTH=7 PIPE=1 SAT=1 (latency 4) and WIDTH=33 PIPE=0 SAT=0 (latency 1).
module tb_csa_pipe_adder;
  logic clk;
  logic rst_n;

  csa_pipe_adder_if #(.WIDTH(16)) b16 ();
  csa_pipe_adder_if #(.WIDTH(7))  b7 ();
  csa_pipe_adder_if #(.WIDTH(33)) b33 ();

  csa_pipe_adder #(.WIDTH(16), .PIPE(1'b1), .SAT(1'b0)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  csa_pipe_adder #(.WIDTH(7),  .PIPE(1'b1), .SAT(1'b1)) u7  (.clk(clk), .rst_n(rst_n), .bus(b7));
  csa_pipe_adder #(.WIDTH(33), .PIPE(1'b0), .SAT(1'b0)) u33 (.clk(clk), .rst_n(rst_n), .bus(b33));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit lat_chk = 1'b1;

  logic [17:0] exp_q[$];
  int          cyc_q[$];
  logic [8:0]  exp7_q[$];
  int          cyc7_q[$];
  logic [34:0] exp33_q[$];
  int          cyc33_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got out_valid=1 required no pending result (cycle %0d)", name, cyc);
  endtask

  // Reference: plain two's-complement arithmetic on 64-bit integers.
  // Returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] xa, ya,
                                            input bit ci, sb, sat);
    logic [63:0] mask, xm_v, yy, sraw, s;
    logic [64:0] full;
    logic        co, xm, ym, ov;
    mask = (64'd1 << w) - 64'd1;
    xm_v = xa & mask;
    yy   = sb ? (~ya & mask) : (ya & mask);
    full = {1'b0, xm_v} + {1'b0, yy} + ((sb || ci) ? 65'd1 : 65'd0);
    sraw = full[63:0] & mask;
    co   = full[w];
    xm   = xm_v[w-1];
    ym   = yy[w-1];
    ov   = (xm == ym) && (sraw[w-1] != xm);
    s    = sraw;
    if (sat && ov) s = xm ? (64'd1 << (w - 1)) : (mask >> 1);
    return {ov, co, s};
  endfunction

  function automatic logic [17:0] m16(input logic [15:0] xa, ya, input bit ci, sb);
    logic [65:0] r;
    r = ref_model(16, {48'd0, xa}, {48'd0, ya}, ci, sb, 1'b0);
    return {r[65], r[64], r[15:0]};
  endfunction

  // ---------------- driver / scoreboard for the 16-bit instance ----------------
  // Drive one cycle's inputs, then score what is visible 1 time unit after the
  // falling edge. The caller advances with tick().
  task automatic drive16(input bit v, input logic [15:0] xa, ya, input bit ci, sb,
                         input bit ordy, input logic [17:0] expv, output bit acc);
    logic [17:0] e;
    int          t;
    b16.in_valid  = v;
    b16.x         = xa;
    b16.y         = ya;
    b16.cin       = ci;
    b16.sub       = sb;
    b16.out_ready = ordy;
    #1;
    acc = v && b16.in_ready;
    if (b16.out_valid && ordy) begin
      if (exp_q.size() == 0) unexpected("w16_unexpected_out");
      else begin
        e = exp_q.pop_front();
        t = cyc_q.pop_front();
        check("w16_result", {46'd0, b16.ovf, b16.cout, b16.sum}, {46'd0, e});
        if (lat_chk) check("w16_latency", 64'(cyc - t), 64'd5);
      end
    end
    if (acc) begin
      exp_q.push_back(expv);
      cyc_q.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle16();
    bit acc;
    drive16(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, 18'd0, acc);
    tick();
  endtask

  task automatic drain16(input string name);
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) idle16();
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cyc_q.delete();
    // Extra idle cycles catch any duplicated or stray result.
    repeat (6) idle16();
  endtask

  // ---------------- random streams on the side instances (always ready) ----------------
  task automatic run_side(input int ncyc);
    logic [65:0] r;
    logic [6:0]  x7, y7;
    logic [32:0] x33, y33;
    bit          v7, v33, c7, s7, c33, s33;
    logic [8:0]  e7;
    logic [34:0] e33;
    int          t;
    for (int n = 0; n < ncyc; n++) begin
      v7  = (n < ncyc - 10) && ($urandom_range(0, 3) != 0);
      v33 = (n < ncyc - 10) && ($urandom_range(0, 3) != 0);
      x7  = 7'($urandom);  y7  = 7'($urandom);
      c7  = 1'($urandom);  s7  = 1'($urandom);
      x33 = 33'({$urandom, $urandom}); y33 = 33'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) x33 = 33'h0_FFFF_FFFF;
      c33 = 1'($urandom);  s33 = 1'($urandom);
      b7.in_valid = v7;   b7.x = x7;   b7.y = y7;   b7.cin = c7;   b7.sub = s7;   b7.out_ready = 1'b1;
      b33.in_valid = v33; b33.x = x33; b33.y = y33; b33.cin = c33; b33.sub = s33; b33.out_ready = 1'b1;
      #1;
      if (b7.out_valid) begin
        if (exp7_q.size() == 0) unexpected("w7_unexpected_out");
        else begin
          e7 = exp7_q.pop_front();
          t  = cyc7_q.pop_front();
          check("w7_result", {55'd0, b7.ovf, b7.cout, b7.sum}, {55'd0, e7});
          check("w7_latency", 64'(cyc - t), 64'd4);
        end
      end
      if (b33.out_valid) begin
        if (exp33_q.size() == 0) unexpected("w33_unexpected_out");
        else begin
          e33 = exp33_q.pop_front();
          t   = cyc33_q.pop_front();
          check("w33_result", {29'd0, b33.ovf, b33.cout, b33.sum}, {29'd0, e33});
          check("w33_latency", 64'(cyc - t), 64'd1);
        end
      end
      if (v7 && b7.in_ready) begin
        r = ref_model(7, {57'd0, x7}, {57'd0, y7}, c7, s7, 1'b1);
        exp7_q.push_back({r[65], r[64], r[6:0]});
        cyc7_q.push_back(cyc);
      end
      if (v33 && b33.in_ready) begin
        r = ref_model(33, {31'd0, x33}, {31'd0, y33}, c33, s33, 1'b0);
        exp33_q.push_back({r[65], r[64], r[32:0]});
        cyc33_q.push_back(cyc);
      end
      tick();
    end
    check("w7_drained", 64'(exp7_q.size()), 64'd0);
    check("w33_drained", 64'(exp33_q.size()), 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        tbl [11];
  bit          acc;
  int          idx;
  int          n_acc;
  logic [17:0] hold_val;
  logic [15:0] rx, ry;
  bit          rc, rs, pend, ordy;

  initial begin
    tbl[0]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[8]  = '{16'd10,   16'd3,    1'b1, 1'b1, 16'd7,    1'b1, 1'b0};
    tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    b7.in_valid = 1'b0;  b7.x = '0;  b7.y = '0;  b7.cin = 1'b0;  b7.sub = 1'b0;  b7.out_ready = 1'b1;
    b33.in_valid = 1'b0; b33.x = '0; b33.y = '0; b33.cin = 1'b0; b33.sub = 1'b0; b33.out_ready = 1'b1;

    // Reset with in_valid held high.
    rst_n = 1'b1;
    b16.in_valid = 1'b1; b16.x = 16'd1; b16.y = 16'd1; b16.cin = 1'b0; b16.sub = 1'b0;
    b16.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    #1;
    check("rst_out_valid", {63'd0, b16.out_valid}, 64'd0);
    check("rst_sum", {48'd0, b16.sum}, 64'd0);
    check("rst_cout", {63'd0, b16.cout}, 64'd0);
    check("rst_ovf", {63'd0, b16.ovf}, 64'd0);
    check("rst_in_ready", {63'd0, b16.in_ready}, 64'd1);
    tick();

    // First op after reset: 1 + 1 emerges 5 cycles after acceptance.
    rst_n = 1'b1;
    lat_chk = 1'b1;
    drive16(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1, 18'h00002, acc);
    check("first_accept", {63'd0, acc}, 64'd1);
    tick();
    drain16("first");

    // Table vectors back-to-back; expectations come from the table.
    for (int i = 0; i < 11; i++) begin
      drive16(1'b1, tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub, 1'b1,
              {tbl[i].ovf, tbl[i].cout, tbl[i].sum}, acc);
      check("tbl_accept", {63'd0, acc}, 64'd1);
      tick();
    end
    drain16("tbl");

    // Backpressure: 8 ops streamed, out_ready low on relative cycles 6..9.
    lat_chk = 1'b0;
    idx = 0;
    hold_val = '0;
    for (int rel = 0; rel < 60 && (idx < 8 || exp_q.size() > 0); rel++) begin
      ordy = !(rel >= 6 && rel <= 9);
      rx = 16'h1111 * 16'(idx + 1) + 16'h7000;
      ry = 16'h0F0F ^ 16'(idx * 37);
      drive16(idx < 8, rx, ry, idx[0], idx[1], ordy, m16(rx, ry, idx[0], idx[1]), acc);
      if (!ordy) begin
        check("bp_in_ready", {63'd0, b16.in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, b16.out_valid}, 64'd1);
        if (rel == 6) hold_val = {b16.ovf, b16.cout, b16.sum};
        else check("bp_hold", {46'd0, b16.ovf, b16.cout, b16.sum}, {46'd0, hold_val});
      end
      if (acc) idx++;
      tick();
    end
    check("bp_all_accepted", 64'(idx), 64'd8);
    drain16("bp");

    // Reset with three ops in flight: none may emerge, and a new op takes 5 cycles.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1, 16'(i + 100), 16'd9, 1'b0, 1'b0, 1'b1, 18'd0, acc);
      tick();
    end
    b16.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, b16.out_valid}, 64'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    drive16(1'b1, 16'h0100, 16'h0023, 1'b1, 1'b0, 1'b1, m16(16'h0100, 16'h0023, 1'b1, 1'b0), acc);
    tick();
    drain16("midrst");

    // Random stream with random stalls; the source holds operands until accepted.
    lat_chk = 1'b0;
    n_acc = 0;
    pend = 1'b0;
    rx = '0; ry = '0; rc = 1'b0; rs = 1'b0;
    for (int n = 0; n < 8000 && n_acc < 2000; n++) begin
      if (!pend) begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        if ($urandom_range(0, 7) == 0) rx = 16'h7FFF;
        if ($urandom_range(0, 7) == 0) ry = 16'h8000;
        rc = 1'($urandom);
        rs = 1'($urandom);
        pend = ($urandom_range(0, 3) != 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive16(pend, rx, ry, rc, rs, ordy, m16(rx, ry, rc, rs), acc);
      if (acc) begin
        pend = 1'b0;
        n_acc++;
      end
      tick();
    end
    check("rand_accepted", 64'(n_acc), 64'd2000);
    b16.in_valid = 1'b0;
    drain16("rand");

    // Other widths and pipe modes against the same reference.
    run_side(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
